gpio_ctrl: RTL and testbench
============================

Name: gpio_ctrl

Overview:
- GPIO register bank that sits directly downstream of the user-area Wishbone slave, on its CTRL_* strobe/address/data interface (address offsets 0x0–0xF).
- Holds output and direction state for the pads and synchronises pad inputs into the core clock domain.
- With the optional feature compiled in, it also captures rising/falling edges into a sticky status register and raises a level interrupt.

Parameters:
- NGPIO, 16, number of GPIO pins; legal range 1..32. Unused upper data bits read 0 and are ignored on write.
- SYNC_STAGES, 2, depth of the input synchroniser; legal range 2..4.

Ports:
- CLK_I  in  1  core clock; all logic on rising edge.
- RSTN_I  in  1  asynchronous, active-low reset.
- CTRL_WE  in  1  single-cycle write strobe from the bus slave.
- CTRL_ADDR  in  4  byte address; word select = CTRL_ADDR[3:2]; bits [1:0] are ignored.
- CTRL_DATA_IN  in  32  write data.
- CTRL_DATA_OUT  out  32  registered read data for CTRL_ADDR.
- GPIO_IN  in  NGPIO  asynchronous pad inputs.
- GPIO_OUT  out  NGPIO  pad output values.
- GPIO_OE  out  NGPIO  pad output enables; 1 = drive.
- IRQ_O  out  1  level interrupt; exists only with GPIO_IRQ_EN, otherwise tied 0.

Behaviour:
- Register map by word index:
  - 0 OUT (RW)
  - 1 OE (RW)
  - 2 IN (RO, synchronised pad value; writes ignored)
  - 3 EDGE (W1C status; reads 0 without GPIO_IRQ_EN)
- Reset (RSTN_I low, asynchronous): OUT=0, OE=0 (all pins input), synchroniser flops=0, previous-sample reg=0, EDGE=0, CTRL_DATA_OUT=0, IRQ_O=0.
- Write commits on the CLK_I edge where CTRL_WE=1. GPIO_OUT/GPIO_OE change at that edge (0 cycles of additional latency).
- CTRL_WE is edge-qualified upstream, so a held request produces exactly one write. The block does not re-qualify it.
- Read: CTRL_DATA_OUT <= mux(CTRL_ADDR) on every clock, i.e. 1-cycle latency. This is valid before the 2-cycle bus acknowledge.
- A read and a write to the same word in the same cycle return the old value.
- Input path:
  - GPIO_IN passes through SYNC_STAGES flops; the last stage is IN.
  - A pin change appears in IN exactly SYNC_STAGES cycles after it is sampled.
  - prev <= IN every cycle.
- Edge detect: rise = IN & ~prev; fall = ~IN & prev. Evaluated every cycle regardless of OE; output pins may loop back externally.
- EDGE update per bit: next = (EDGE & ~(CTRL_WE && word==3 ? DATA_IN : 0)) | event.
  - A new event wins over a simultaneous W1C clear of the same bit.
  - Writing 0 bits has no effect.
- Pulses narrower than one clock may be missed; this is acceptable.
- Reset mid-transfer: all state returns to reset values immediately. A write in flight is lost.

Optional Feature:
- Macro: GPIO_CTRL_IRQ_EN.
- Defined:
  - Adds registers RISE_EN and FALL_EN at word 3 bits [31:16] and [15:0]? Rejected, as it conflicts with NGPIO. Instead the event is fixed to any edge (rise|fall).
  - EDGE is implemented.
  - IRQ_O is registered: IRQ_O <= |EDGE_next. It asserts 1 cycle after the event is captured and deasserts 1 cycle after the last status bit is cleared.
- Undefined: no EDGE/prev flops, word 3 reads 0, writes to it are ignored, IRQ_O is constant 0.

Decomposition:
- Shared package gpio_ctrl_pkg:
  - word-index constants ADDR_OUT=0, ADDR_OE=1, ADDR_IN=2, ADDR_EDGE=3
  - NGPIO_MAX=32
- One natural sub-module: gpio_sync, a parameterised SYNC_STAGES x NGPIO synchroniser with async active-low reset, reused later for other pad inputs.
- Everything else lives in gpio_ctrl.

Test Plan:
- Reset then reads of words 0..3 -> CTRL_DATA_OUT = 0x0 each cycle after address; GPIO_OE=0, GPIO_OUT=0, IRQ_O=0.
- Write OUT=0x0000A5A5, OE=0x0000FF00 (NGPIO=16) -> GPIO_OUT=0xA5A5 and GPIO_OE=0xFF00 on the strobe edge. Readback returns the same, upper bits 0. Write 0xFFFF0000 to OUT -> reads 0x0.
- Drive GPIO_IN=0x1234 at cycle t -> word 2 reads 0x1234 from cycle t+SYNC_STAGES+1. A write of 0xFFFF to word 2 leaves it unchanged.
- (IRQ_EN) GPIO_IN bit 3 rises -> EDGE=0x0008 and IRQ_O=1 one cycle later. Write 0x0008 to word 3 -> EDGE=0, IRQ_O drops next cycle. Writing 0x0000 leaves the bit set.
- (IRQ_EN) Bit 5 toggles in the same cycle as a W1C of bit 5 -> bit 5 remains set and IRQ_O stays 1.
- Assert RSTN_I low mid-sequence with OUT=0xFFFF, EDGE≠0 -> all outputs 0 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/gpio_ctrl_pkg.sv
// Shared constants for the GPIO register bank: the bus word map and the pin-count ceiling.
package gpio_ctrl_pkg;

  typedef enum logic [1:0] {
    ADDR_OUT  = 2'd0,
    ADDR_OE   = 2'd1,
    ADDR_IN   = 2'd2,
    ADDR_EDGE = 2'd3
  } gpio_word_e;

  localparam int NGPIO_MAX = 32;

endpackage

// File: rtl/gpio_sync.sv
// Multi-stage flop synchroniser for a bus of asynchronous pad inputs.
// The last stage is the synchronised output; all stages clear on async reset.
module gpio_sync #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q;
  logic [STAGES-1:0][WIDTH-1:0] sync_d;

  // Shift the pad value one stage deeper every clock.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
  end

  // Synchroniser stage registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/gpio_ctrl.sv
// GPIO register bank on the CTRL_* strobe interface: OUT/OE registers, synchronised IN,
// and with GPIO_CTRL_IRQ_EN defined a sticky any-edge EDGE status plus level interrupt.
module gpio_ctrl
  import gpio_ctrl_pkg::*;
#(
  parameter int NGPIO       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK_I,
  input  logic             RSTN_I,
  input  logic             CTRL_WE,
  input  logic [3:0]       CTRL_ADDR,
  input  logic [31:0]      CTRL_DATA_IN,
  output logic [31:0]      CTRL_DATA_OUT,
  input  logic [NGPIO-1:0] GPIO_IN,
  output logic [NGPIO-1:0] GPIO_OUT,
  output logic [NGPIO-1:0] GPIO_OE,
  output logic             IRQ_O
);

  logic [1:0]       word_s;
  logic [NGPIO-1:0] wdata_s;
  logic [NGPIO-1:0] in_s;
  logic [NGPIO-1:0] edge_rd_s;
  logic [NGPIO-1:0] rd_sel_s;
  logic [NGPIO-1:0] out_q, out_d;
  logic [NGPIO-1:0] oe_q, oe_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             unused_s;

  assign word_s   = CTRL_ADDR[3:2];
  assign wdata_s  = CTRL_DATA_IN[NGPIO-1:0];
  // Byte-offset bits and data bits above NGPIO carry no meaning here.
  assign unused_s = ^{CTRL_ADDR[1:0], CTRL_DATA_IN};

  gpio_sync #(
    .WIDTH  (NGPIO),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i  (CLK_I),
    .rst_ni (RSTN_I),
    .d_i    (GPIO_IN),
    .q_o    (in_s)
  );

  // Next-state for the writable OUT and OE registers.
  always_comb begin
    out_d = out_q;
    oe_d  = oe_q;
    if (CTRL_WE) begin
      case (word_s)
        ADDR_OUT: out_d = wdata_s;
        ADDR_OE:  oe_d  = wdata_s;
        default:  ;
      endcase
    end else begin
      out_d = out_q;
      oe_d  = oe_q;
    end
  end

  // Read mux built from current register values, so a same-cycle write reads old data.
  always_comb begin
    rd_sel_s = '0;
    case (word_s)
      ADDR_OUT:  rd_sel_s = out_q;
      ADDR_OE:   rd_sel_s = oe_q;
      ADDR_IN:   rd_sel_s = in_s;
      ADDR_EDGE: rd_sel_s = edge_rd_s;
      default:   rd_sel_s = '0;
    endcase
    rdata_d              = 32'h0000_0000;
    rdata_d[NGPIO-1:0]   = rd_sel_s;
  end

  // Control registers and the registered read port.
  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      out_q   <= '0;
      oe_q    <= '0;
      rdata_q <= 32'h0000_0000;
    end else begin
      out_q   <= out_d;
      oe_q    <= oe_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef GPIO_CTRL_IRQ_EN
  logic [NGPIO-1:0] prev_q;
  logic [NGPIO-1:0] edge_q, edge_d;
  logic [NGPIO-1:0] clr_s;
  logic [NGPIO-1:0] evt_s;
  logic             irq_q, irq_d;

  // Any-edge capture; a fresh event beats a simultaneous W1C of the same bit.
  always_comb begin
    clr_s = '0;
    if (CTRL_WE && (word_s == ADDR_EDGE)) begin
      clr_s = wdata_s;
    end else begin
      clr_s = '0;
    end
    evt_s  = in_s ^ prev_q;
    edge_d = (edge_q & ~clr_s) | evt_s;
    irq_d  = |edge_d;
  end

  // Previous-sample, sticky status and interrupt registers.
  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      prev_q <= '0;
      edge_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      prev_q <= in_s;
      edge_q <= edge_d;
      irq_q  <= irq_d;
    end
  end

  assign edge_rd_s = edge_q;
  assign IRQ_O     = irq_q;
`else
  assign edge_rd_s = '0;
  assign IRQ_O     = 1'b0;
`endif

  assign GPIO_OUT      = out_q;
  assign GPIO_OE       = oe_q;
  assign CTRL_DATA_OUT = rdata_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed self-checking bench for gpio_ctrl (NGPIO=16, SYNC_STAGES=2).
// Edge/interrupt checks are compiled in only when GPIO_CTRL_IRQ_EN is defined.
module tb_gpio_ctrl;

  localparam int NGPIO = 16;
  localparam int SYNC  = 2;

  logic             clk;
  logic             rstn;
  logic             we;
  logic [3:0]       addr;
  logic [31:0]      wdata;
  logic [31:0]      rdata;
  logic [NGPIO-1:0] gin;
  logic [NGPIO-1:0] gout;
  logic [NGPIO-1:0] goe;
  logic             irq;

  int n_cmp;
  int n_bad;

  gpio_ctrl #(
    .NGPIO       (NGPIO),
    .SYNC_STAGES (SYNC)
  ) dut (
    .CLK_I         (clk),
    .RSTN_I        (rstn),
    .CTRL_WE       (we),
    .CTRL_ADDR     (addr),
    .CTRL_DATA_IN  (wdata),
    .CTRL_DATA_OUT (rdata),
    .GPIO_IN       (gin),
    .GPIO_OUT      (gout),
    .GPIO_OE       (goe),
    .IRQ_O         (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rstn  = 1'b0;
    we    = 1'b0;
    addr  = 4'h0;
    wdata = 32'h0000_0000;
    gin   = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out", {16'h0000, gout}, 32'h0000_0000);
    check_eq("rst_oe", {16'h0000, goe}, 32'h0000_0000);
    check_eq("rst_irq", {31'h0, irq}, 32'h0000_0000);
    @(negedge clk);
    rstn = 1'b1;

    // Reads of every word after reset.
    for (int w = 0; w < 4; w++) begin
      addr = 4'(w * 4);
      tick();
      check_eq($sformatf("rst_rd_w%0d", w), rdata, 32'h0000_0000);
    end

    // OUT / OE writes take effect on the strobe edge.
    we = 1'b1; addr = 4'h0; wdata = 32'h0000_A5A5;
    tick();
    check_eq("wr_out", {16'h0000, gout}, 32'h0000_A5A5);
    addr = 4'h4; wdata = 32'h0000_FF00;
    tick();
    check_eq("wr_oe", {16'h0000, goe}, 32'h0000_FF00);
    we = 1'b0; addr = 4'h0;
    tick();
    check_eq("rd_out", rdata, 32'h0000_A5A5);
    addr = 4'h5;
    tick();
    check_eq("rd_oe_byteoff", rdata, 32'h0000_FF00);

    // Same-cycle read and write of a word returns the old contents.
    we = 1'b1; addr = 4'h0; wdata = 32'h0000_1111;
    tick();
    check_eq("rw_old", rdata, 32'h0000_A5A5);
    check_eq("rw_out", {16'h0000, gout}, 32'h0000_1111);

    // Upper data bits are ignored on write.
    wdata = 32'hFFFF_0000;
    tick();
    we = 1'b0;
    tick();
    check_eq("rd_out_upper", rdata, 32'h0000_0000);
    check_eq("out_upper", {16'h0000, gout}, 32'h0000_0000);

    // Input synchroniser latency: visible on the read port SYNC+1 edges after driving.
    addr = 4'h8;
    gin  = 16'h1234;
    tick();
    tick();
    check_eq("in_early", rdata, 32'h0000_0000);
    tick();
    check_eq("in_sync", rdata, 32'h0000_1234);

    // IN is read-only.
    we = 1'b1; wdata = 32'h0000_FFFF;
    tick();
    we = 1'b0;
    tick();
    check_eq("in_ro", rdata, 32'h0000_1234);
    check_eq("in_ro_out", {16'h0000, gout}, 32'h0000_0000);
    check_eq("in_ro_oe", {16'h0000, goe}, 32'h0000_FF00);

    // Clear all status; word 3 then reads 0 in either build.
    we = 1'b1; addr = 4'hC; wdata = 32'h0000_FFFF;
    tick();
    we = 1'b0;
    check_eq("clr_irq", {31'h0, irq}, 32'h0000_0000);
    tick();
    check_eq("rd_edge_clr", rdata, 32'h0000_0000);

`ifdef GPIO_CTRL_IRQ_EN
    // Rise on bit 3 sets EDGE and the interrupt.
    gin = 16'h123C;
    tick();
    tick();
    tick();
    check_eq("irq_rise", {31'h0, irq}, 32'h0000_0001);
    tick();
    check_eq("edge_rise", rdata, 32'h0000_0008);

    // W1C of bit 3.
    we = 1'b1; wdata = 32'h0000_0008;
    tick();
    we = 1'b0;
    check_eq("irq_w1c", {31'h0, irq}, 32'h0000_0000);
    tick();
    check_eq("edge_w1c", rdata, 32'h0000_0000);

    // Re-arm with a fall on bit 3, then writing zeros leaves it set.
    gin = 16'h1234;
    tick();
    tick();
    tick();
    we = 1'b1; wdata = 32'h0000_0000;
    tick();
    we = 1'b0;
    tick();
    check_eq("edge_w0", rdata, 32'h0000_0008);
    check_eq("irq_w0", {31'h0, irq}, 32'h0000_0001);

    // Bit 5 falls in the very cycle bits 5 and 3 are cleared: bit 5 survives.
    gin = 16'h1214;
    tick();
    tick();
    we = 1'b1; wdata = 32'h0000_0028;
    tick();
    we = 1'b0;
    check_eq("irq_race", {31'h0, irq}, 32'h0000_0001);
    tick();
    check_eq("edge_race", rdata, 32'h0000_0020);
`else
    // Without the edge feature word 3 stays 0 and no interrupt appears.
    gin = 16'h123C;
    repeat (4) tick();
    check_eq("noirq_edge", rdata, 32'h0000_0000);
    check_eq("noirq_irq", {31'h0, irq}, 32'h0000_0000);
`endif

    // Asynchronous reset mid-sequence clears outputs before the next edge.
    we = 1'b1; addr = 4'h0; wdata = 32'h0000_FFFF;
    tick();
    we = 1'b0;
    tick();
    check_eq("pre_rst_out", {16'h0000, gout}, 32'h0000_FFFF);
    check_eq("pre_rst_rd", rdata, 32'h0000_FFFF);
    #2;
    rstn = 1'b0;
    #1;
    check_eq("arst_out", {16'h0000, gout}, 32'h0000_0000);
    check_eq("arst_oe", {16'h0000, goe}, 32'h0000_0000);
    check_eq("arst_rd", rdata, 32'h0000_0000);
    check_eq("arst_irq", {31'h0, irq}, 32'h0000_0000);
    @(negedge clk);
    rstn = 1'b1;
    tick();
    check_eq("post_rst_rd", rdata, 32'h0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
